// File: rtl/tti_rx_desc_gen.sv
// TTI RX descriptor generator: counts the bytes of each private write and
// pushes one {addr, sat, count} descriptor when the transfer closes.
module tti_rx_desc_gen #(
  parameter int RxDescDataWidth = 32,
  parameter int CountWidth      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       bus_start_i,
  input  logic                       bus_stop_i,
  input  logic [7:0]                 bus_addr_i,
  input  logic                       bus_addr_valid_i,
  input  logic                       rx_data_wvalid_i,
  input  logic                       rx_data_wready_i,
  output logic                       rx_desc_queue_wvalid_o,
  input  logic                       rx_desc_queue_wready_i,
  output logic [RxDescDataWidth-1:0] rx_desc_queue_wdata_o,
  output logic                       desc_drop_o,
  output logic                       busy_o
);

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_e;

  localparam logic [CountWidth-1:0] CountMax = {CountWidth{1'b1}};

  state_e                     state_q, state_d;
  logic [7:0]                 addr_q, addr_d;
  logic [CountWidth-1:0]      count_q, count_d;
  logic                       sat_q, sat_d;
  logic                       hold_valid_q, hold_valid_d;
  logic [RxDescDataWidth-1:0] hold_data_q, hold_data_d;
  logic                       drop_q, drop_d;
  logic                       busy_q, busy_d;

  logic                       byte_acc;
  logic                       drain;
  logic                       close;
  logic [CountWidth-1:0]      count_inc;
  logic                       sat_inc;
  logic [RxDescDataWidth-1:0] closed_desc;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    sat_d        = sat_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    drop_d       = 1'b0;
    close        = 1'b0;

    byte_acc = rx_data_wvalid_i & rx_data_wready_i;
    drain    = hold_valid_q & rx_desc_queue_wready_i;

    // A byte landing in the closing cycle must be part of the closed count.
    count_inc = count_q;
    sat_inc   = sat_q;
    if (byte_acc) begin
      if (count_q == CountMax) begin
        sat_inc = 1'b1;
      end else begin
        count_inc = count_q + CountWidth'(1);
      end
    end

    closed_desc                          = '0;
    closed_desc[CountWidth-1:0]          = count_inc;
    closed_desc[CountWidth]              = sat_inc;
    closed_desc[RxDescDataWidth-1 -: 8]  = addr_q;

    if (drain) begin
      hold_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus_addr_valid_i && !bus_addr_i[0]) begin
          state_d = StActive;
          addr_d  = bus_addr_i;
          count_d = '0;
          sat_d   = 1'b0;
        end
      end
      StActive: begin
        count_d = count_inc;
        sat_d   = sat_inc;
        if (bus_stop_i || bus_start_i) begin
          close   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // The slot can take a new entry only if empty or emptying this cycle.
    if (close) begin
      if (!hold_valid_q || drain) begin
        hold_valid_d = 1'b1;
        hold_data_d  = closed_desc;
      end else begin
        drop_d = 1'b1;
      end
    end

    if (!enable_i) begin
      state_d      = StIdle;
      count_d      = '0;
      sat_d        = 1'b0;
      hold_valid_d = 1'b0;
      hold_data_d  = '0;
      drop_d       = 1'b0;
    end

    busy_d = (state_d == StActive) | hold_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      count_q      <= '0;
      sat_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_desc_queue_wvalid_o = hold_valid_q;
  assign rx_desc_queue_wdata_o  = hold_data_q;
  assign desc_drop_o            = drop_q;
  assign busy_o                 = busy_q;

endmodule

// File: tb/tb_tti_rx_desc_gen.sv
// Self-checking bench for tti_rx_desc_gen: directed scenarios plus randomized
// transfers compared against a descriptor model derived from byte totals.
module tb_tti_rx_desc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        bus_start;
  logic        bus_stop;
  logic [7:0]  bus_addr;
  logic        bus_addr_valid;
  logic        rx_wvalid;
  logic        rx_wready;
  logic        desc_wvalid;
  logic        desc_wready;
  logic [31:0] desc_wdata;
  logic        desc_drop;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int dropCount = 0;
  int checkedIdx = 0;
  logic [31:0] expQ[$];
  logic [31:0] gotQ[$];

  tti_rx_desc_gen #(
    .RxDescDataWidth(32),
    .CountWidth(16)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .enable_i              (enable),
    .bus_start_i           (bus_start),
    .bus_stop_i            (bus_stop),
    .bus_addr_i            (bus_addr),
    .bus_addr_valid_i      (bus_addr_valid),
    .rx_data_wvalid_i      (rx_wvalid),
    .rx_data_wready_i      (rx_wready),
    .rx_desc_queue_wvalid_o(desc_wvalid),
    .rx_desc_queue_wready_i(desc_wready),
    .rx_desc_queue_wdata_o (desc_wdata),
    .desc_drop_o           (desc_drop),
    .busy_o                (busy)
  );

  always #5 clk = ~clk;

  // Record every completed descriptor handshake and every drop pulse.
  always @(negedge clk) begin
    if (rst_n && desc_wvalid && desc_wready) gotQ.push_back(desc_wdata);
    if (desc_drop) dropCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expDesc(input logic [7:0] addr, input int total);
    logic [31:0] d;
    d = {addr, 24'h000000};
    if (total > 65535) d = d | 32'h0001_FFFF;
    else d[15:0] = total[15:0];
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One write transfer: address strobe, nBytes accepted, then STOP or Sr.
  task automatic applyStimulus(input logic [7:0] addr, input int nBytes,
                               input bit closeWithStart, input bit lastOnClose,
                               input bit fullRate, input bit expectDesc);
    int acc = 0;
    int cycles = 0;
    bit v, r;
    bus_addr = addr;
    bus_addr_valid = 1'b1;
    tick();
    bus_addr_valid = 1'b0;
    while (acc < nBytes && cycles < nBytes * 20 + 50) begin
      v = fullRate ? 1'b1 : 1'($urandom_range(0, 1));
      r = fullRate ? 1'b1 : 1'($urandom_range(0, 1));
      rx_wvalid = v;
      rx_wready = r;
      tick();
      cycles++;
      if (v && r) acc++;
    end
    if (acc < nBytes) checkOutput("byte_budget", 32'(acc), 32'(nBytes));
    rx_wvalid = lastOnClose;
    rx_wready = lastOnClose;
    bus_start = closeWithStart;
    bus_stop  = !closeWithStart;
    tick();
    rx_wvalid = 1'b0;
    rx_wready = 1'b0;
    bus_start = 1'b0;
    bus_stop  = 1'b0;
    if (expectDesc) expQ.push_back(expDesc(addr, acc + int'(lastOnClose)));
  endtask

  task automatic checkQueues(input string tag);
    int n;
    tick();
    tick();
    checkOutput({tag, "_count"}, 32'(gotQ.size()), 32'(expQ.size()));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = checkedIdx; i < n; i++) checkOutput({tag, "_desc"}, gotQ[i], expQ[i]);
    checkedIdx = expQ.size();
  endtask

  initial begin
    logic [7:0] a;
    int base;
    rst_n = 1'b0; enable = 1'b1; bus_start = 1'b0; bus_stop = 1'b0;
    bus_addr = 8'h00; bus_addr_valid = 1'b0; rx_wvalid = 1'b0; rx_wready = 1'b0;
    desc_wready = 1'b1;
    repeat (3) tick();
    checkOutput("reset_wvalid", 32'(desc_wvalid), 32'd0);
    checkOutput("reset_wdata", desc_wdata, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_drop", 32'(desc_drop), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic write of 3 bytes
    applyStimulus(8'hB4, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1_wvalid_rise", 32'(desc_wvalid), 32'd1);
    checkOutput("t1_wdata", desc_wdata, 32'hB400_0003);
    tick();
    checkOutput("t1_wvalid_fall", 32'(desc_wvalid), 32'd0);
    checkQueues("t1");

    // Byte coincident with STOP, then an ignored read
    applyStimulus(8'hB4, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    checkQueues("t2");
    bus_addr = 8'hB5; bus_addr_valid = 1'b1;
    tick();
    bus_addr_valid = 1'b0;
    checkOutput("t2_read_busy0", 32'(busy), 32'd0);
    for (int i = 0; i < 2; i++) begin
      rx_wvalid = 1'b1; rx_wready = 1'b1;
      tick();
      checkOutput("t2_read_busy", 32'(busy), 32'd0);
    end
    rx_wvalid = 1'b0; rx_wready = 1'b0; bus_stop = 1'b1;
    tick();
    bus_stop = 1'b0;
    checkOutput("t2_read_nodesc", 32'(desc_wvalid), 32'd0);
    checkQueues("t2_read");

    // Backpressure and drop
    desc_wready = 1'b0;
    base = dropCount;
    applyStimulus(8'hB4, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t3_held", 32'(desc_wvalid), 32'd1);
    applyStimulus(8'h22, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_drop_pulse", 32'(desc_drop), 32'd1);
    checkOutput("t3_held_data", desc_wdata, 32'hB400_0001);
    tick();
    checkOutput("t3_drop_end", 32'(desc_drop), 32'd0);
    desc_wready = 1'b1;
    checkQueues("t3");
    checkOutput("t3_drop_count", 32'(dropCount - base), 32'd1);

    // Repeated START then zero-byte write
    applyStimulus(8'hB4, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hB4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkQueues("t4");

    // Saturation
    applyStimulus(8'hB4, 65537, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_sat", expQ[expQ.size() - 1], 32'hB401_FFFF);
    checkQueues("t5");

    // Randomized writes with interleaved ignored reads
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = 8'($urandom_range(0, 127) << 1) | 8'h01;
        bus_addr = a; bus_addr_valid = 1'b1;
        tick();
        bus_addr_valid = 1'b0;
        rx_wvalid = 1'b1; rx_wready = 1'($urandom_range(0, 1));
        tick();
        rx_wvalid = 1'b0; rx_wready = 1'b0;
        checkOutput("rnd_read_busy", 32'(busy), 32'd0);
      end
      a = 8'($urandom_range(0, 127) << 1);
      applyStimulus(a, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    checkQueues("rnd");

    // Reset mid-transfer with a held descriptor
    desc_wready = 1'b0;
    applyStimulus(8'h10, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_addr = 8'hB4; bus_addr_valid = 1'b1;
    tick();
    bus_addr_valid = 1'b0;
    rx_wvalid = 1'b1; rx_wready = 1'b1;
    tick();
    rx_wvalid = 1'b0; rx_wready = 1'b0;
    checkOutput("t6_pre_wvalid", 32'(desc_wvalid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("t6_wvalid", 32'(desc_wvalid), 32'd0);
    checkOutput("t6_wdata", desc_wdata, 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_drop", 32'(desc_drop), 32'd0);
    bus_stop = 1'b1;
    tick();
    bus_stop = 1'b0;
    tick();
    checkOutput("t6_post_stop", 32'(desc_wvalid), 32'd0);

    // Disable mid-transfer with a held descriptor
    applyStimulus(8'h12, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_addr = 8'hB4; bus_addr_valid = 1'b1;
    tick();
    bus_addr_valid = 1'b0;
    rx_wvalid = 1'b1; rx_wready = 1'b1;
    tick();
    rx_wvalid = 1'b0; rx_wready = 1'b0;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    checkOutput("t7_wvalid", 32'(desc_wvalid), 32'd0);
    checkOutput("t7_wdata", desc_wdata, 32'd0);
    checkOutput("t7_busy", 32'(busy), 32'd0);
    bus_stop = 1'b1;
    tick();
    bus_stop = 1'b0;
    tick();
    checkOutput("t7_post_stop", 32'(desc_wvalid), 32'd0);
    desc_wready = 1'b1;
    checkQueues("t67");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tti_rx_desc_gen.md
Name: tti_rx_desc_gen

Overview:
Generates TTI RX descriptors for the I3C standby controller. The RX descriptor write port is currently tied off at the standby top level; this block drives it instead. It snoops the RX-data-queue write handshake, the bus start/stop strobes and the matched-address strobe, then counts the bytes of each private write. When the transfer closes (STOP or repeated START) it pushes one 32-bit descriptor into the RX descriptor queue.

Parameters:
RxDescDataWidth, 32, descriptor word width; must be 32.
CountWidth, 16, byte-counter width; occupies descriptor bits [CountWidth-1:0].

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
enable_i  input  1  block enable (i3c_standby_en)
bus_start_i  input  1  START/Sr strobe, 1 cycle
bus_stop_i  input  1  STOP strobe, 1 cycle
bus_addr_i  input  8  {addr[6:0], RnW}
bus_addr_valid_i  input  1  address matched this device, 1-cycle strobe
rx_data_wvalid_i  input  1  snooped RX data queue wvalid
rx_data_wready_i  input  1  snooped RX data queue wready
rx_desc_queue_wvalid_o  output  1  descriptor valid
rx_desc_queue_wready_i  input  1  descriptor queue ready
rx_desc_queue_wdata_o  output  RxDescDataWidth  descriptor
desc_drop_o  output  1  1-cycle pulse: descriptor lost
busy_o  output  1  transfer open or descriptor pending

Behaviour:
- Descriptor layout: [15:0] byte count; [16] count saturated; [23:17] zero; [31:24] bus_addr_i captured at the address strobe.
- Byte accepted = rx_data_wvalid_i & rx_data_wready_i.
- Collector FSM:
  - IDLE: on bus_addr_valid_i with RnW=0, latch the address, clear the count, go to ACTIVE.
  - IDLE: an address strobe with RnW=1 (read) is ignored, and the FSM stays in IDLE.
  - ACTIVE: each accepted byte increments the count. The count saturates at 16'hFFFF, sets the saturate bit, and stays there.
  - ACTIVE: bus_stop_i or bus_start_i closes the transfer. The closed {addr, sat, count} is moved to the holding register, and the FSM returns to IDLE.
  - A byte accepted in the same cycle as the closing strobe is counted in the closing descriptor.
  - ACTIVE: a repeated START followed by a new address strobe opens a new transfer from IDLE. The address strobe of the same transfer never coincides with its closing strobe.
  - A zero-byte write (address then STOP) produces a descriptor with count 0.
- Holding register: one entry; its valid bit drives rx_desc_queue_wvalid_o.
  - wvalid asserts the cycle after the close.
  - wdata is stable while wvalid=1 and wready=0.
  - Handshake completes when wvalid & wready; wvalid deasserts the next cycle unless a new close is loaded in that same cycle.
  - A close while the holding register is valid and not being drained that cycle: the new descriptor is discarded, desc_drop_o pulses 1 cycle, and the held entry is unchanged.
  - A close in the same cycle as a drain handshake loads the new entry (back-to-back, no gap).
- busy_o = (state==ACTIVE) | holding valid.
- enable_i=0: FSM forced to IDLE, counter cleared, holding register cleared, inputs ignored. A transfer in progress is abandoned without a descriptor.
- Reset (rst_ni=0 at a clk_i edge), including mid-transfer or with wvalid high:
  - state IDLE, count 0;
  - rx_desc_queue_wvalid_o=0, rx_desc_queue_wdata_o=0;
  - desc_drop_o=0, busy_o=0.
- All outputs are registered. No combinational path from rx_desc_queue_wready_i to rx_desc_queue_wvalid_o.

Test Plan:
- Address 0x5A write (bus_addr_i=8'hB4), 3 bytes accepted, STOP, wready=1 -> one descriptor 32'hB400_0003; wvalid high exactly 1 cycle, starting 1 cycle after STOP.
- Byte accepted in the same cycle as STOP after 4 prior bytes -> count 5. Read address strobe (8'hB5) followed by 2 snooped handshakes -> no descriptor, busy_o stays 0.
- wready=0 with a descriptor held; a second write of 1 byte closes -> desc_drop_o pulses once; the held descriptor is unchanged. Raise wready -> only the first descriptor is written.
- Repeated START closes write #1 (2 bytes) while wready=1; write #2 (0 bytes) closes with STOP -> descriptors 32'hB400_0002 then 32'hB400_0000, in order.
- 65 537 accepted bytes -> descriptor 32'hB401_FFFF.
- rst_ni=0 for 1 cycle mid-transfer with wvalid=1 -> all outputs 0 next cycle; the later STOP produces no descriptor.
- enable_i=0 mid-transfer -> same result as reset.
